// File: rtl/buzzer_pkg.sv
// Shared types and constants for the beep-pattern generator.
package buzzer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    localparam int DEF_CLK_HZ = 48_000_000;
    localparam int DEF_DIV_W  = 24;
    localparam int DEF_DUR_W  = 16;
    localparam int DEF_REP_W  = 8;

    // Clock cycles per millisecond for a given input clock.
    function automatic int ms_div(input int clk_hz);
        return clk_hz / 1000;
    endfunction

endpackage

// File: rtl/buzzer_seq_if.sv
// Controller-side bundle for buzzer_seq: pattern request, programming fields and status.
interface buzzer_seq_if
    import buzzer_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W,
    parameter int DUR_W = DEF_DUR_W,
    parameter int REP_W = DEF_REP_W
) ();

    logic             start;
    logic             stop;
    logic [DIV_W-1:0] half_div;
    logic [DUR_W-1:0] on_ms;
    logic [DUR_W-1:0] off_ms;
    logic [REP_W-1:0] reps;
    logic             BP;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, half_div, on_ms, off_ms, reps,
        input  BP, busy, done
    );

    modport slave (
        input  start, stop, half_div, on_ms, off_ms, reps,
        output BP, busy, done
    );

endinterface

// File: rtl/buzzer_seq_tone_div.sv
// Square-tone divider: registered output toggling every half_div enabled cycles.
module tone_div
    import buzzer_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] half_div,
    output logic             tone
);

    logic [DIV_W-1:0] cnt;

    // clr restarts the phase high; with neither clr nor en the output parks low.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt  <= '0;
            tone <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tone <= (half_div != '0);
        end else if (en) begin
            if (half_div == '0) begin
                cnt  <= '0;
                tone <= 1'b0;
            end else if (cnt == half_div - 1'b1) begin
                cnt  <= '0;
                tone <= ~tone;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt  <= '0;
            tone <= 1'b0;
        end
    end

endmodule

// File: rtl/buzzer_seq.sv
// Beep-pattern generator: N gated tone bursts with programmable on/off lengths in ms.
module buzzer_seq
    import buzzer_pkg::*;
#(
    parameter int CLK_HZ = DEF_CLK_HZ,
    parameter int DIV_W  = DEF_DIV_W,
    parameter int DUR_W  = DEF_DUR_W,
    parameter int REP_W  = DEF_REP_W
) (
    input  logic         CLK,
    input  logic         RST_N,
    buzzer_seq_if.slave  bus
);

    localparam int MS_DIV = ms_div(CLK_HZ);
    localparam int PRE_W  = $clog2(MS_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MS_DIV - 1);

    state_t           state;
    logic [PRE_W-1:0] pre;
    logic [DUR_W-1:0] ms_cnt;
    logic [REP_W-1:0] beep_cnt;
    logic             busy_r;
    logic             done_r;

    logic [DIV_W-1:0] half_r;
    logic [DUR_W-1:0] on_r;
    logic [DUR_W-1:0] off_r;
    logic [REP_W-1:0] reps_r;

    logic             pre_last;
    logic             on_end;
    logic             off_end;
    logic [REP_W-1:0] beep_nxt;
    logic             last_beep;
    logic             accept;
    logic             reenter;
    logic [PRE_W-1:0] pre_step;
    logic [DUR_W-1:0] ms_step;
    logic             tone_clr;
    logic             tone_en;
    logic [DIV_W-1:0] tone_hd;
    logic             tone;

    // Phase timing: prescaler and ms counter both restart at every phase entry.
    always_comb begin
        pre_last  = (pre == PRE_LAST);
        pre_step  = pre_last ? '0 : pre + 1'b1;
        ms_step   = pre_last ? ms_cnt + 1'b1 : ms_cnt;
        on_end    = (state == ON)  && pre_last && (ms_cnt == on_r - 1'b1);
        off_end   = (state == OFF) && pre_last && (ms_cnt == off_r - 1'b1);
        beep_nxt  = (beep_cnt == '1) ? beep_cnt : beep_cnt + 1'b1;
        last_beep = (reps_r != '0) && (beep_nxt == reps_r);
        accept    = (state == IDLE) && bus.start && !bus.stop;
        reenter   = on_end && !last_beep && (off_r == '0);
    end

    // Tone restarts on every ON entry; the divider sees the live field only at accept.
    always_comb begin
        tone_clr = !bus.stop && (accept || reenter || off_end);
        tone_en  = !bus.stop && (state == ON) && !on_end;
        tone_hd  = (state == IDLE) ? bus.half_div : half_r;
    end

    tone_div #(
        .DIV_W (DIV_W)
    ) u_tone (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .clr      (tone_clr),
        .en       (tone_en),
        .half_div (tone_hd),
        .tone     (tone)
    );

    // Programming fields are captured once per pattern; on_ms=0 is stored as 1 ms.
    always_ff @(posedge CLK) begin
        if (accept) begin
            half_r <= bus.half_div;
            on_r   <= (bus.on_ms == '0) ? DUR_W'(1) : bus.on_ms;
            off_r  <= bus.off_ms;
            reps_r <= bus.reps;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            pre      <= '0;
            ms_cnt   <= '0;
            beep_cnt <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (bus.stop) begin
                state    <= IDLE;
                pre      <= '0;
                ms_cnt   <= '0;
                beep_cnt <= '0;
                busy_r   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            state    <= ON;
                            pre      <= '0;
                            ms_cnt   <= '0;
                            beep_cnt <= '0;
                            busy_r   <= 1'b1;
                        end
                    end
                    ON: begin
                        if (on_end) begin
                            beep_cnt <= beep_nxt;
                            pre      <= '0;
                            ms_cnt   <= '0;
                            if (last_beep) begin
                                state  <= IDLE;
                                busy_r <= 1'b0;
                                done_r <= 1'b1;
                            end else if (off_r == '0) begin
                                state <= ON;
                            end else begin
                                state <= OFF;
                            end
                        end else begin
                            pre    <= pre_step;
                            ms_cnt <= ms_step;
                        end
                    end
                    OFF: begin
                        if (off_end) begin
                            state  <= ON;
                            pre    <= '0;
                            ms_cnt <= '0;
                        end else begin
                            pre    <= pre_step;
                            ms_cnt <= ms_step;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.BP   = tone;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule

// File: tb/tb_buzzer_seq.sv
// Scoreboard bench for buzzer_seq at CLK_HZ=10_000 (10 cycles per ms).
module tb_buzzer_seq;
    import buzzer_pkg::*;

    localparam int CLK_HZ = 10_000;
    localparam int DIV_W  = 24;
    localparam int DUR_W  = 16;
    localparam int REP_W  = 8;

    typedef struct {
        int    cyc;
        logic  bp;
        logic  busy;
        logic  done;
        string tag;
    } exp_t;

    logic  CLK   = 1'b0;
    logic  RST_N = 1'b0;
    int    cyc   = 0;
    int    total = 0;
    int    bad   = 0;
    string cur_tag = "reset";
    exp_t  q[$];

    buzzer_seq_if #(.DIV_W(DIV_W), .DUR_W(DUR_W), .REP_W(REP_W)) bus ();

    buzzer_seq #(
        .CLK_HZ (CLK_HZ),
        .DIV_W  (DIV_W),
        .DUR_W  (DUR_W),
        .REP_W  (REP_W)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Tone level j cycles into an ON phase: high for the first half_div cycles.
    function automatic logic tone_at(input int h, input int j);
        return (h != 0) && (((j / h) % 2) == 0);
    endfunction

    task automatic push(input int c, input logic bp, input logic busy, input logic done);
        exp_t e;
        e.cyc = c; e.bp = bp; e.busy = busy; e.done = done; e.tag = cur_tag;
        q.push_back(e);
    endtask

    task automatic push_on(input int c0, input int len, input int h);
        for (int j = 0; j < len; j++) push(c0 + j, tone_at(h, j), 1'b1, 1'b0);
    endtask

    task automatic push_off(input int c0, input int len);
        for (int j = 0; j < len; j++) push(c0 + j, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic push_idle(input int c0, input int len);
        for (int j = 0; j < len; j++) push(c0 + j, 1'b0, 1'b0, 1'b0);
    endtask

    // Drives a start at the current negedge; k is the edge that samples it.
    task automatic issue_start(input int hd, input int on, input int off, input int rp,
                               output int k);
        @(negedge CLK);
        bus.half_div = DIV_W'(hd);
        bus.on_ms    = DUR_W'(on);
        bus.off_ms   = DUR_W'(off);
        bus.reps     = REP_W'(rp);
        bus.start    = 1'b1;
        k = cyc + 1;
    endtask

    task automatic release_start();
        @(negedge CLK);
        bus.start = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge CLK);
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && q.size() > 0; i++) @(negedge CLK);
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout %s: %0d expectations left, want 0", cur_tag, q.size());
            q.delete();
        end
        @(negedge CLK);
    endtask

    // Monitor: compares outputs against the expectation queued for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                total++;
                bad++;
                $display("FAIL %s missed check at cyc %0d (now %0d)", e.tag, e.cyc, cyc);
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                total++;
                if ({bus.BP, bus.busy, bus.done} !== {e.bp, e.busy, e.done}) begin
                    bad++;
                    $display("FAIL %s cyc=%0d BP/busy/done got=%b%b%b want=%b%b%b",
                             e.tag, cyc, bus.BP, bus.busy, bus.done, e.bp, e.busy, e.done);
                end
            end
        end
    end

    initial begin
        int k;
        bus.start = 1'b0; bus.stop = 1'b0;
        bus.half_div = '0; bus.on_ms = '0; bus.off_ms = '0; bus.reps = '0;

        cur_tag = "reset";
        push_idle(1, 3);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        drain();

        // Two beeps, 3 ms on / 2 ms off, tone toggling every 2 cycles.
        cur_tag = "two_beeps";
        issue_start(2, 3, 2, 2, k);
        push_on(k, 30, 2);
        push_off(k + 30, 20);
        push_on(k + 50, 30, 2);
        push(k + 80, 1'b0, 1'b0, 1'b1);
        push_idle(k + 81, 3);
        release_start();
        drain();

        cur_tag = "silent_tone";
        issue_start(0, 1, 5, 1, k);
        push_on(k, 10, 0);
        push(k + 10, 1'b0, 1'b0, 1'b1);
        push_idle(k + 11, 3);
        release_start();
        drain();

        // Continuous 1 ms beeps with no gap, aborted by stop sampled at edge k+57.
        cur_tag = "continuous_stop";
        issue_start(3, 1, 0, 0, k);
        for (int j = 0; j < 57; j++) push(k + j, tone_at(3, j % 10), 1'b1, 1'b0);
        push_idle(k + 57, 6);
        release_start();
        wait_until(k + 56);
        bus.stop = 1'b1;
        @(negedge CLK);
        bus.stop = 1'b0;
        drain();

        cur_tag = "start_while_busy";
        issue_start(2, 2, 1, 2, k);
        push_on(k, 20, 2);
        push_off(k + 20, 10);
        push_on(k + 30, 20, 2);
        push(k + 50, 1'b0, 1'b0, 1'b1);
        push_idle(k + 51, 3);
        release_start();
        wait_until(k + 5);
        bus.half_div = DIV_W'(5); bus.on_ms = DUR_W'(7); bus.off_ms = '0; bus.reps = REP_W'(1);
        bus.start = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
        wait_until(k + 25);
        bus.start = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
        drain();

        cur_tag = "start_and_stop";
        @(negedge CLK);
        bus.half_div = DIV_W'(2); bus.on_ms = DUR_W'(1); bus.off_ms = '0; bus.reps = REP_W'(1);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        push_idle(cyc + 1, 5);
        @(negedge CLK);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        drain();

        // Asynchronous reset in the middle of an OFF gap.
        cur_tag = "reset_mid_off";
        issue_start(2, 1, 3, 2, k);
        push_on(k, 10, 2);
        push_off(k + 10, 5);
        push_idle(k + 15, 2);
        release_start();
        wait_until(k + 14);
        @(posedge CLK);
        #2 RST_N = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        drain();

        cur_tag = "after_reset";
        issue_start(1, 2, 4, 1, k);
        push_on(k, 20, 1);
        push(k + 20, 1'b0, 1'b0, 1'b1);
        push_idle(k + 21, 3);
        release_start();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
